// File: rtl/instruction_dispatcher_if.sv
// Bundle of upstream instruction, memory-control and status signals of the dispatcher.
// The master modport is the environment side, the slave modport is the dispatcher.
interface instruction_dispatcher_if;
    logic [31:0] instr_data;
    logic        instr_valid;
    logic        instr_ready;

    logic [2:0]  mc_operation;
    logic [16:0] mc_addr_base;
    logic [7:0]  mc_color;
    logic [2:0]  mc_zoom;
    logic        mc_enable;
    logic        mc_done;

    logic        busy;
    logic [4:0]  fifo_count;
    logic        error;
    logic [1:0]  error_code;
    logic        error_clear;

    modport master (
        output instr_data,
        output instr_valid,
        input  instr_ready,
        input  mc_operation,
        input  mc_addr_base,
        input  mc_color,
        input  mc_zoom,
        input  mc_enable,
        output mc_done,
        input  busy,
        input  fifo_count,
        input  error,
        input  error_code,
        output error_clear
    );

    modport slave (
        input  instr_data,
        input  instr_valid,
        output instr_ready,
        output mc_operation,
        output mc_addr_base,
        output mc_color,
        output mc_zoom,
        output mc_enable,
        input  mc_done,
        output busy,
        output fifo_count,
        output error,
        output error_code,
        input  error_clear
    );
endinterface

// File: rtl/instruction_dispatcher.sv
// Instruction FIFO feeding a decode/issue FSM that hands one drawing command at a time
// to the memory controller, with range/opcode checks and a sticky error report.
module instruction_dispatcher #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ADDR_LIMIT  = 76800,
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input logic                     clock,
    input logic                     reset_n,
    instruction_dispatcher_if.slave bus_io
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [2:0] OpNop = 3'b000;
    localparam logic [2:0] OpRd  = 3'b001;
    localparam logic [2:0] OpWr  = 3'b010;
    localparam logic [2:0] OpIll = 3'b111;

    localparam logic [1:0] ErrNone    = 2'b00;
    localparam logic [1:0] ErrOpcode  = 2'b01;
    localparam logic [1:0] ErrAddr    = 2'b10;
    localparam logic [1:0] ErrTimeout = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StIssue,
        StAck,
        StRun
    } state_e;

    // ---------------------------------------------------------------- FIFO
    // Bit 31 is reserved and never stored.
    logic [30:0]     fifo_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]      count_q, count_d;
    logic            fifo_ready;
    logic            push;
    logic            pop;
    logic            unused_reserved;

    assign unused_reserved = bus_io.instr_data[31];
    assign fifo_ready      = (count_q < 5'(FIFO_DEPTH));
    assign push            = bus_io.instr_valid && fifo_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= bus_io.instr_data[30:0];
        end
    end

    // ---------------------------------------------------------------- FSM
    state_e          state_q, state_d;
    logic [30:0]     instr_q, instr_d;
    logic [2:0]      mc_op_q, mc_op_d;
    logic [16:0]     mc_addr_q, mc_addr_d;
    logic [7:0]      mc_color_q, mc_color_d;
    logic [2:0]      mc_zoom_q, mc_zoom_d;
    logic [CntW-1:0] ack_cnt_q, ack_cnt_d;
    logic            error_q, error_d;
    logic [1:0]      error_code_q, error_code_d;
    logic            mc_enable;
    logic            set_err;
    logic [1:0]      new_code;

    logic [2:0]  instr_op;
    logic [16:0] instr_addr;
    logic [7:0]  instr_color;
    logic [2:0]  instr_zoom;
    logic        addr_bad;

    assign instr_op    = instr_q[2:0];
    assign instr_addr  = instr_q[19:3];
    assign instr_color = instr_q[27:20];
    assign instr_zoom  = instr_q[30:28];
    // Only plain reads/writes are range-checked; algorithms may use the field freely.
    assign addr_bad    = ((instr_op == OpRd) || (instr_op == OpWr)) &&
                         ({15'd0, instr_addr} >= ADDR_LIMIT);

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        mc_op_d    = mc_op_q;
        mc_addr_d  = mc_addr_q;
        mc_color_d = mc_color_q;
        mc_zoom_d  = mc_zoom_q;
        ack_cnt_d  = ack_cnt_q;
        pop        = 1'b0;
        mc_enable  = 1'b0;
        set_err    = 1'b0;
        new_code   = ErrNone;

        unique case (state_q)
            StIdle: begin
                if ((count_q != 5'd0) && bus_io.mc_done) begin
                    pop     = 1'b1;
                    instr_d = fifo_mem_q[rd_ptr_q];
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = StIdle;
                if (instr_op == OpNop) begin
                    state_d = StIdle;
                end else if (instr_op == OpIll) begin
                    set_err  = 1'b1;
                    new_code = ErrOpcode;
                end else if (addr_bad) begin
                    set_err  = 1'b1;
                    new_code = ErrAddr;
                end else begin
                    mc_op_d    = instr_op;
                    mc_addr_d  = instr_addr;
                    mc_color_d = instr_color;
                    mc_zoom_d  = instr_zoom;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                mc_enable = 1'b1;
                ack_cnt_d = '0;
                state_d   = StAck;
            end
            StAck: begin
                if (!bus_io.mc_done) begin
                    state_d = StRun;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                    if (ack_cnt_d == CntW'(ACK_TIMEOUT)) begin
                        set_err  = 1'b1;
                        new_code = ErrTimeout;
                        state_d  = StIdle;
                    end
                end
            end
            StRun: begin
                if (bus_io.mc_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A fresh error takes priority over a clear arriving in the same cycle.
    always_comb begin
        error_d      = error_q;
        error_code_d = error_code_q;
        if (set_err) begin
            error_d      = 1'b1;
            error_code_d = new_code;
        end else if (bus_io.error_clear) begin
            error_d      = 1'b0;
            error_code_d = ErrNone;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            instr_q      <= '0;
            mc_op_q      <= '0;
            mc_addr_q    <= '0;
            mc_color_q   <= '0;
            mc_zoom_q    <= '0;
            ack_cnt_q    <= '0;
            error_q      <= 1'b0;
            error_code_q <= ErrNone;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            instr_q      <= instr_d;
            mc_op_q      <= mc_op_d;
            mc_addr_q    <= mc_addr_d;
            mc_color_q   <= mc_color_d;
            mc_zoom_q    <= mc_zoom_d;
            ack_cnt_q    <= ack_cnt_d;
            error_q      <= error_d;
            error_code_q <= error_code_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign bus_io.instr_ready  = fifo_ready;
    assign bus_io.mc_operation = mc_op_q;
    assign bus_io.mc_addr_base = mc_addr_q;
    assign bus_io.mc_color     = mc_color_q;
    assign bus_io.mc_zoom      = mc_zoom_q;
    assign bus_io.mc_enable    = mc_enable;
    assign bus_io.busy         = (state_q != StIdle) || (count_q != 5'd0);
    assign bus_io.fifo_count   = count_q;
    assign bus_io.error        = error_q;
    assign bus_io.error_code   = error_code_q;

    // ---------------------------------------------------------------- checks
    a_enable_single: assert property (@(posedge clock) disable iff (!reset_n)
        bus_io.mc_enable |=> !bus_io.mc_enable);
    a_count_bound: assert property (@(posedge clock) disable iff (!reset_n)
        count_q <= 5'(FIFO_DEPTH));
    a_run_stable: assert property (@(posedge clock) disable iff (!reset_n)
        (state_q == StRun) |=> $stable({mc_op_q, mc_addr_q, mc_color_q, mc_zoom_q}));

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Randomised and directed bench for instruction_dispatcher against a transaction-level
// model (queue of words plus the in-flight command's age since it left the queue).
module tb_instruction_dispatcher;

    localparam int unsigned Depth   = 4;
    localparam int unsigned Limit   = 76800;
    localparam int unsigned Timeout = 8;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    instruction_dispatcher_if bus ();

    instruction_dispatcher #(
        .FIFO_DEPTH (Depth),
        .ADDR_LIMIT (Limit),
        .ACK_TIMEOUT(Timeout)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus_io (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic [16:0] addr;
        logic [7:0]  color;
        logic [2:0]  zoom;
    } issue_t;
    issue_t issued[$];
    int     last_en_cyc = -1;

    // Reference model state.
    logic [31:0] m_q[$];
    bit          m_inflight;
    logic [31:0] m_w;
    int          m_age;
    bit          m_started;
    int          m_ack_n;
    bit          m_err;
    logic [1:0]  m_code;
    logic [2:0]  m_op;
    logic [16:0] m_addr;
    logic [7:0]  m_color;
    logic [2:0]  m_zoom;

    // Memory-controller stand-in: 0 normal, 1 done stuck high, 2 done stuck low.
    int mem_mode = 0;
    int mem_left = 0;
    int run_len  = 3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mkword(input logic [2:0] op, input logic [16:0] addr,
                                           input logic [7:0] color, input logic [2:0] zoom);
        return {1'b0, zoom, color, addr, op};
    endfunction

    function automatic logic [1:0] fault_of(input logic [31:0] w);
        if (w[2:0] == 3'b111) return 2'b01;
        if ((w[2:0] == 3'b001 || w[2:0] == 3'b010) && (32'(w[19:3]) >= Limit)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit issues(input logic [31:0] w);
        return (w[2:0] != 3'b000) && (fault_of(w) == 2'b00);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_inflight = 0;
        m_age      = 0;
        m_started  = 0;
        m_ack_n    = 0;
        m_err      = 0;
        m_code     = 2'b00;
        m_op       = '0;
        m_addr     = '0;
        m_color    = '0;
        m_zoom     = '0;
    endtask

    task automatic compare_outputs();
        check("instr_ready", bus.instr_ready, m_q.size() < Depth);
        check("fifo_count", bus.fifo_count, m_q.size());
        check("busy", bus.busy, m_inflight || (m_q.size() != 0));
        check("mc_enable", bus.mc_enable, m_inflight && (m_age == 2));
        check("mc_operation", bus.mc_operation, m_op);
        check("mc_addr_base", bus.mc_addr_base, m_addr);
        check("mc_color", bus.mc_color, m_color);
        check("mc_zoom", bus.mc_zoom, m_zoom);
        check("error", bus.error, m_err);
        check("error_code", bus.error_code, m_code);
    endtask

    // Advance the model across one clock edge using the inputs now on the bus.
    task automatic model_step();
        bit         room  = m_q.size() < Depth;
        bit         fault = 0;
        logic [1:0] fcode = 2'b00;
        if (m_inflight) begin
            if (m_age == 1) begin
                if (!issues(m_w)) begin
                    m_inflight = 0;
                    fcode      = fault_of(m_w);
                    fault      = (fcode != 2'b00);
                end else begin
                    m_op    = m_w[2:0];
                    m_addr  = m_w[19:3];
                    m_color = m_w[27:20];
                    m_zoom  = m_w[30:28];
                    m_age   = 2;
                end
            end else if (m_age == 2) begin
                m_age     = 3;
                m_started = 0;
                m_ack_n   = 0;
            end else if (!m_started) begin
                if (!bus.mc_done) begin
                    m_started = 1;
                end else begin
                    m_ack_n++;
                    if (m_ack_n == Timeout) begin
                        fault      = 1;
                        fcode      = 2'b11;
                        m_inflight = 0;
                    end
                end
            end else if (bus.mc_done) begin
                m_inflight = 0;
            end
        end else if ((m_q.size() > 0) && bus.mc_done) begin
            m_w        = m_q.pop_front();
            m_inflight = 1;
            m_age      = 1;
        end
        if (bus.instr_valid && room) m_q.push_back(bus.instr_data);
        if (fault) begin
            m_err  = 1;
            m_code = fcode;
        end else if (bus.error_clear) begin
            m_err  = 0;
            m_code = 2'b00;
        end
    endtask

    task automatic tick(input bit valid, input logic [31:0] data, input bit clr, output bit acc);
        @(negedge clock);
        cyc++;
        bus.instr_valid = valid;
        bus.instr_data  = data;
        bus.error_clear = clr;
        case (mem_mode)
            1:       bus.mc_done = 1'b1;
            2:       bus.mc_done = 1'b0;
            default: begin
                if (mem_left > 0) begin
                    bus.mc_done = 1'b0;
                    mem_left--;
                end else begin
                    bus.mc_done = 1'b1;
                end
            end
        endcase
        acc = valid && bus.instr_ready;
        compare_outputs();
        if (bus.mc_enable) begin
            issued.push_back({bus.mc_operation, bus.mc_addr_base, bus.mc_color, bus.mc_zoom});
            last_en_cyc = cyc;
            if (mem_mode == 0) mem_left = run_len;
        end
        model_step();
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) tick(1'b0, 32'd0, 1'b0, acc);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_enable"}, bus.mc_enable, 1'b0);
        check({tag, "_op"}, bus.mc_operation, 3'b000);
        check({tag, "_addr"}, bus.mc_addr_base, 17'd0);
        check({tag, "_color"}, bus.mc_color, 8'd0);
        check({tag, "_zoom"}, bus.mc_zoom, 3'd0);
        check({tag, "_error"}, bus.error, 1'b0);
        check({tag, "_code"}, bus.error_code, 2'b00);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_count"}, bus.fifo_count, 5'd0);
    endtask

    function automatic logic [31:0] rand_word();
        logic [16:0] a;
        case ($urandom_range(0, 4))
            0:       a = 17'(Limit - 1);
            1:       a = 17'(Limit);
            2:       a = 17'($urandom_range(Limit + 1, 131071));
            default: a = 17'($urandom_range(0, Limit - 1));
        endcase
        return {1'($urandom_range(0, 1)), mkword(3'($urandom_range(0, 7)), a,
                8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)))} ;
    endfunction

    initial begin
        bit acc;
        int base;
        int t_err;
        bit done_wait;
        bus.instr_valid = 1'b0;
        bus.instr_data  = '0;
        bus.error_clear = 1'b0;
        bus.mc_done     = 1'b1;
        model_reset();
        #12;
        check_reset_values("reset");
        @(negedge clock);
        reset_n = 1'b1;
        idle(2);

        // Single write, done low 1 cycle after enable for 3 cycles.
        run_len = 3;
        base    = issued.size();
        tick(1'b1, mkword(3'b010, 17'd100, 8'hAB, 3'd0), 1'b0, acc);
        idle(15);
        check("wr_issue_count", issued.size() - base, 1);
        if (issued.size() > base) begin
            check("wr_op", issued[base].op, 3'b010);
            check("wr_addr", issued[base].addr, 17'd100);
            check("wr_color", issued[base].color, 8'hAB);
        end
        check("wr_busy_after", bus.busy, 1'b0);

        // Fill the FIFO while memory control reports busy.
        mem_mode = 2;
        base     = issued.size();
        for (int i = 0; i < 4; i++) tick(1'b1, mkword(3'b010, 17'(i * 10), 8'(i), 3'd1), 1'b0, acc);
        tick(1'b1, mkword(3'b010, 17'd999, 8'h55, 3'd2), 1'b0, acc);
        check("full_ready", bus.instr_ready, 1'b0);
        check("full_count", bus.fifo_count, 5'd4);
        check("full_5th_taken", acc, 1'b0);
        mem_mode  = 0;
        run_len   = 1;
        done_wait = 0;
        for (int i = 0; i < 40 && !done_wait; i++) begin
            tick(1'b1, mkword(3'b010, 17'd999, 8'h55, 3'd2), 1'b0, acc);
            done_wait = acc;
        end
        check("full_5th_eventually", done_wait, 1'b1);
        idle(60);
        check("full_issue_count", issued.size() - base, 5);
        check("full_busy_after", bus.busy, 1'b0);

        // Illegal opcode, then out-of-range read, then the last legal address.
        run_len = 2;
        base    = issued.size();
        tick(1'b1, mkword(3'b111, 17'd0, 8'd0, 3'd0), 1'b0, acc);
        idle(5);
        check("ill_code", bus.error_code, 2'b01);
        tick(1'b1, mkword(3'b001, 17'(Limit), 8'd0, 3'd0), 1'b0, acc);
        idle(5);
        check("range_code", bus.error_code, 2'b10);
        tick(1'b1, mkword(3'b001, 17'(Limit - 1), 8'd0, 3'd0), 1'b0, acc);
        idle(15);
        check("range_issue_count", issued.size() - base, 1);
        if (issued.size() > base) check("range_issue_addr", issued[base].addr, 17'd76799);
        check("range_code_kept", bus.error_code, 2'b10);

        // Acknowledge timeout with done stuck high, then clear.
        mem_mode = 1;
        t_err    = -1;
        tick(1'b1, mkword(3'b001, 17'd5, 8'd0, 3'd0), 1'b0, acc);
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 32'd0, 1'b0, acc);
            if (t_err < 0 && bus.error_code == 2'b11) t_err = cyc;
        end
        check("timeout_code", bus.error_code, 2'b11);
        check("timeout_latency", t_err - last_en_cyc, Timeout + 1);
        check("timeout_idle", bus.busy, 1'b0);
        tick(1'b0, 32'd0, 1'b1, acc);
        idle(1);
        check("clear_error", bus.error, 1'b0);
        mem_mode = 0;

        // NOP dropped, algorithm opcode with an address beyond the frame buffer.
        run_len = 2;
        base    = issued.size();
        tick(1'b1, mkword(3'b000, 17'd7, 8'd1, 3'd1), 1'b0, acc);
        tick(1'b1, mkword(3'b011, 17'd100000, 8'h3C, 3'b100), 1'b0, acc);
        idle(20);
        check("algo_issue_count", issued.size() - base, 1);
        if (issued.size() > base) begin
            check("algo_op", issued[base].op, 3'b011);
            check("algo_zoom", issued[base].zoom, 3'b100);
        end
        check("algo_no_error", bus.error, 1'b0);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            run_len = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 5));
            tick(($urandom_range(0, 2) != 0), rand_word(), ($urandom_range(0, 19) == 0), acc);
        end
        run_len = 2;
        idle(80);

        // Reset while a command runs with three words queued.
        run_len = 40;
        base    = issued.size();
        tick(1'b1, mkword(3'b010, 17'd1, 8'd1, 3'd0), 1'b0, acc);
        tick(1'b1, mkword(3'b010, 17'd2, 8'd2, 3'd0), 1'b0, acc);
        tick(1'b1, mkword(3'b010, 17'd3, 8'd3, 3'd0), 1'b0, acc);
        tick(1'b1, mkword(3'b010, 17'd4, 8'd4, 3'd0), 1'b0, acc);
        done_wait = 0;
        for (int i = 0; i < 20 && !done_wait; i++) begin
            tick(1'b0, 32'd0, 1'b0, acc);
            done_wait = m_inflight && m_started;
        end
        check("run_reached", done_wait, 1'b1);
        check("run_queued", bus.fifo_count, 5'd3);
        #2;
        reset_n         = 1'b0;
        bus.instr_valid = 1'b0;
        bus.error_clear = 1'b0;
        bus.mc_done     = 1'b1;
        #1;
        check_reset_values("midrun");
        model_reset();
        mem_left = 0;
        base     = issued.size();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        idle(10);
        check("post_reset_no_enable", issued.size() - base, 0);
        check("post_reset_count", bus.fifo_count, 5'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_dispatcher.md
INSTRUCTION_DISPATCHER -- requirements
Module: instruction_dispatcher

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: instruction FIFO depth in words; legal values are powers of two, 2..16.
REQ-002 Parameter ADDR_LIMIT, default 76800: first illegal frame-buffer address (320x240).
REQ-003 Parameter ACK_TIMEOUT, default 8: maximum cycles to wait for mc_done to fall after issue.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-005 clock  in  1  rising-edge system clock.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 instr_data  in  32  instruction word: [2:0] opcode, [19:3] address, [27:20] color, [30:28] zoom, [31] reserved (ignored).
REQ-008 instr_valid  in  1  upstream word valid.
REQ-009 instr_ready  out  1  FIFO can accept a word; a word is taken when instr_valid&&instr_ready at a clock edge.
REQ-010 mc_operation  out  3  opcode to memory control (001 RD, 010 WR, 011..110 algorithms).
REQ-011 mc_addr_base  out  17  address to memory control.
REQ-012 mc_color  out  8  write color to memory control.
REQ-013 mc_zoom  out  3  zoom level to memory control.
REQ-014 mc_enable  out  1  single-cycle start pulse.
REQ-015 mc_done  in  1  memory control idle/complete flag (high when idle, low while executing).
REQ-016 busy  out  1  high whenever FSM is not in S_IDLE or the FIFO is non-empty.
REQ-017 fifo_count  out  5  current FIFO occupancy, 0..FIFO_DEPTH.
REQ-018 error  out  1  sticky error flag.
REQ-019 error_code  out  2  00 none, 01 illegal opcode, 10 address out of range, 11 ack timeout.
REQ-020 error_clear  in  1  synchronous clear of error and error_code.

Function
REQ-021 FIFO: circular buffer; instr_ready = (fifo_count < FIFO_DEPTH); a simultaneous push and pop when full is not possible (ready low), and when neither full nor empty occupancy is unchanged.
REQ-022 A word pushed into an empty FIFO is poppable no earlier than the next cycle (no bypass).
REQ-023 FSM states: S_IDLE, S_DECODE, S_ISSUE, S_ACK, S_RUN.
REQ-024 S_IDLE: if FIFO non-empty and mc_done==1, pop the head word into an internal register and go to S_DECODE; otherwise stay.
REQ-025 S_DECODE, opcode 000 (NOP): discard and return to S_IDLE, no error.
REQ-026 S_DECODE, opcode 111: discard, set error=1 and error_code=01, and return to S_IDLE.
REQ-027 S_DECODE, opcode 001/010 with address >= ADDR_LIMIT: discard, set error=1 and error_code=10, and return to S_IDLE.
REQ-028 S_DECODE, otherwise: load mc_operation, mc_addr_base, mc_color and mc_zoom from the word and go to S_ISSUE; for opcodes 011..110 the address is not range-checked.
REQ-029 S_ISSUE: mc_enable=1 for exactly this one cycle; go to S_ACK and clear the timeout counter.
REQ-030 S_ACK: if mc_done==0, go to S_RUN; otherwise increment the counter, and on reaching ACK_TIMEOUT set error=1 and error_code=11 and go to S_IDLE.
REQ-031 S_RUN: hold all mc_* data outputs stable; on mc_done==1 go to S_IDLE.
REQ-032 mc_enable is never high outside S_ISSUE.
REQ-033 Minimum issue-to-issue spacing is 4 cycles plus the memory-control execution time.
REQ-034 Error is sticky: a later error overwrites error_code; error_clear and a new error in the same cycle leave error=1 with the new code.
REQ-035 FIFO pushes continue in every FSM state; an error does not flush the FIFO.

Reset
REQ-036 On reset_n=0, immediately: FSM=S_IDLE, FIFO empty, fifo_count=0, instr_ready=1 after release, mc_enable=0, mc_operation=000, mc_addr_base=0, mc_color=0, mc_zoom=0, error=0, error_code=00, busy=0.
REQ-037 Reset asserted mid-operation abandons the instruction in flight and all queued words; no mc_enable pulse may occur in the cycle reset is released.

Verification
REQ-038 Push WR word (addr 100, color 0xAB); model done falling 1 cycle after enable and rising 3 cycles later -> exactly one mc_enable pulse with mc_operation=010, mc_addr_base=100, mc_color=0xAB; busy=0 afterward.
REQ-039 Push 5 words back-to-back while mc_done is held low -> instr_ready=0 after the 4th, fifo_count=4, and the 5th word is not accepted until a pop occurs.
REQ-040 Push opcode 111, then RD with addr 76800, then RD with addr 76799 -> error_code=01, then 10, and exactly one enable issued, for addr 76799.
REQ-041 Issue with mc_done stuck high -> after 8 S_ACK cycles error_code=11 and the FSM is in S_IDLE; error_clear -> error=0.
REQ-042 Drop reset_n during S_RUN with 3 words queued -> all outputs at reset values immediately; fifo_count=0 and no enable after release.
REQ-043 Push NOP, then an algorithm opcode 011 with zoom 100 -> the NOP is silently dropped and one enable is issued with mc_operation=011 and mc_zoom=100.
